// File: rtl/mux_4a1_pkg.sv
// Shared constants for the 4:1 data selector and its 2:1 building block.
package mux_4a1_pkg;

   // Select encodings for {s1,s0}; s1 is the MSB.
   localparam logic [1:0] SEL_D00 = 2'b00;
   localparam logic [1:0] SEL_D01 = 2'b01;
   localparam logic [1:0] SEL_D10 = 2'b10;
   localparam logic [1:0] SEL_D11 = 2'b11;

   localparam int unsigned DEFAULT_WIDTH = 1;

endpackage

// File: rtl/mux_2a1.sv
// WIDTH-parameterized 2:1 selector, bitwise-parallel across the data word.
module mux_2a1
   import mux_4a1_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic             s,
   output logic [WIDTH-1:0] y
);

   // Full case; an unknown select drives all-X in simulation rather than a merged value.
   always_comb begin
      y = 'x;
      case (s)
         1'b0:    y = d0;
         1'b1:    y = d1;
         default: y = 'x;
      endcase
   end

endmodule

// File: rtl/mux_4a1.sv
// Four-input data selector with a combinational output y and a registered,
// load-enabled copy y_q. Built as a two-level tree of 2:1 selectors.
module mux_4a1
   import mux_4a1_pkg::*;
#(
   parameter int unsigned     WIDTH   = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic [WIDTH-1:0] d00,
   input  logic [WIDTH-1:0] d01,
   input  logic [WIDTH-1:0] d10,
   input  logic [WIDTH-1:0] d11,
   input  logic             s1,
   input  logic             s0,
   output logic [WIDTH-1:0] y,
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [WIDTH-1:0] y_q
);

   logic [WIDTH-1:0] lo_sel;
   logic [WIDTH-1:0] hi_sel;

   // Stage 1: s0 picks within each pair.
   mux_2a1 #(
      .WIDTH (WIDTH)
   ) u_stage1_lo (
      .d0 (d00),
      .d1 (d01),
      .s  (s0),
      .y  (lo_sel)
   );

   mux_2a1 #(
      .WIDTH (WIDTH)
   ) u_stage1_hi (
      .d0 (d10),
      .d1 (d11),
      .s  (s0),
      .y  (hi_sel)
   );

   // Stage 2: s1 picks between the pairs.
   mux_2a1 #(
      .WIDTH (WIDTH)
   ) u_stage2 (
      .d0 (lo_sel),
      .d1 (hi_sel),
      .s  (s1),
      .y  (y)
   );

   // Output register: async reset dominates the load enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_q <= RST_VAL;
      end else if (en) begin
         y_q <= y;
      end
   end

endmodule

// File: tb/tb_mux_4a1.sv
// Self-checking bench for mux_4a1: table-driven combinational vectors,
// exhaustive WIDTH=1 sweep, and hand-written register/reset sequences.
module tb_mux_4a1;
   import mux_4a1_pkg::*;

   localparam logic [7:0] RST_ALT = 8'h5A;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       s1;
   logic       s0;
   logic       a00, a01, a10, a11;
   logic       y1, y1_q;
   logic [7:0] b00, b01, b10, b11;
   logic [7:0] y8, y8_q, y8r, y8r_q;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      name;
      logic [7:0] exp;
   } sb_t;
   sb_t sb[$];

   typedef struct {
      logic [7:0] d00;
      logic [7:0] d01;
      logic [7:0] d10;
      logic [7:0] d11;
      logic [1:0] sel;
      logic [7:0] exp;
   } vec_t;

   mux_4a1 #(
      .WIDTH   (1),
      .RST_VAL (1'b0)
   ) dut1 (
      .d00 (a00), .d01 (a01), .d10 (a10), .d11 (a11),
      .s1  (s1),  .s0  (s0),  .y   (y1),
      .clk (clk), .rst (rst), .en  (en),  .y_q (y1_q)
   );

   mux_4a1 #(
      .WIDTH   (8),
      .RST_VAL (8'h00)
   ) dut8 (
      .d00 (b00), .d01 (b01), .d10 (b10), .d11 (b11),
      .s1  (s1),  .s0  (s0),  .y   (y8),
      .clk (clk), .rst (rst), .en  (en),  .y_q (y8_q)
   );

   mux_4a1 #(
      .WIDTH   (8),
      .RST_VAL (RST_ALT)
   ) dut8r (
      .d00 (b00), .d01 (b01), .d10 (b10), .d11 (b11),
      .s1  (s1),  .s0  (s0),  .y   (y8r),
      .clk (clk), .rst (rst), .en  (en),  .y_q (y8r_q)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, required finish before 100000");
      $fatal(1, "watchdog");
   end

   task automatic expect_val(input string name, input logic [7:0] v);
      sb.push_back('{name, v});
   endtask

   task automatic check_val(input logic [7:0] act);
      sb_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty: got %h, required a queued expectation", act);
      end else begin
         e = sb.pop_front();
         if (act !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", e.name, act, e.exp);
         end
      end
   endtask

   task automatic set_sel(input logic [1:0] sel);
      {s1, s0} = sel;
   endtask

   vec_t v1[$];
   vec_t v8[$];

   initial begin
      // WIDTH=1 directed vectors (bit 0 used).
      v1 = '{
         '{8'd1, 8'd0, 8'd1, 8'd1, SEL_D00, 8'd1},
         '{8'd1, 8'd0, 8'd1, 8'd0, SEL_D10, 8'd1},
         '{8'd1, 8'd0, 8'd1, 8'd0, SEL_D01, 8'd0},
         '{8'd1, 8'd0, 8'd1, 8'd0, SEL_D11, 8'd0}
      };
      // WIDTH=8 vectors; the 5th toggles d00 while 01 is selected.
      v8 = '{
         '{8'hA5, 8'h3C, 8'hFF, 8'h00, SEL_D00, 8'hA5},
         '{8'hA5, 8'h3C, 8'hFF, 8'h00, SEL_D01, 8'h3C},
         '{8'hA5, 8'h3C, 8'hFF, 8'h00, SEL_D10, 8'hFF},
         '{8'hA5, 8'h3C, 8'hFF, 8'h00, SEL_D11, 8'h00},
         '{8'h5A, 8'h3C, 8'hFF, 8'h00, SEL_D01, 8'h3C},
         '{8'h0F, 8'hF0, 8'h55, 8'hAA, SEL_D00, 8'h0F},
         '{8'h0F, 8'hF0, 8'h55, 8'hAA, SEL_D01, 8'hF0},
         '{8'h0F, 8'hF0, 8'h55, 8'hAA, SEL_D10, 8'h55},
         '{8'h0F, 8'hF0, 8'h55, 8'hAA, SEL_D11, 8'hAA}
      };

      rst = 1'b1;
      en  = 1'b0;
      {s1, s0} = 2'b00;
      {a00, a01, a10, a11} = 4'b0000;
      {b00, b01, b10, b11} = {8'h00, 8'h00, 8'h00, 8'h00};

      // Reset state before any clock edge.
      #3;
      expect_val("reset_y1_q", 8'h00);
      check_val({7'd0, y1_q});
      expect_val("reset_y8_q", 8'h00);
      check_val(y8_q);
      expect_val("reset_y8r_q", RST_ALT);
      check_val(y8r_q);

      @(negedge clk);
      rst = 1'b0;

      // Combinational vectors, WIDTH=1.
      for (int i = 0; i < v1.size(); i++) begin
         {a00, a01, a10, a11} = {v1[i].d00[0], v1[i].d01[0], v1[i].d10[0], v1[i].d11[0]};
         set_sel(v1[i].sel);
         expect_val($sformatf("w1_vec%0d", i), v1[i].exp);
         #1;
         check_val({7'd0, y1});
      end

      // Exhaustive WIDTH=1: data bits {d00,d01,d10,d11} = i[5:2], select = i[1:0].
      for (int i = 0; i < 64; i++) begin
         logic [5:0] pat;
         logic [3:0] dat;
         logic [1:0] sel;
         pat = i[5:0];
         dat = pat[5:2];
         sel = pat[1:0];
         {a00, a01, a10, a11} = dat;
         set_sel(sel);
         expect_val($sformatf("w1_exh%0d", i), {7'd0, dat[3 - sel]});
         #1;
         check_val({7'd0, y1});
      end

      // Combinational vectors, WIDTH=8, checked on both 8-bit instances.
      for (int i = 0; i < v8.size(); i++) begin
         {b00, b01, b10, b11} = {v8[i].d00, v8[i].d01, v8[i].d10, v8[i].d11};
         set_sel(v8[i].sel);
         expect_val($sformatf("w8_vec%0d", i), v8[i].exp);
         expect_val($sformatf("w8r_vec%0d", i), v8[i].exp);
         #1;
         check_val(y8);
         check_val(y8r);
      end

      // Register: first load of A5, then a mid-cycle reset pulse.
      @(negedge clk);
      {b00, b01, b10, b11} = {8'hA5, 8'h3C, 8'hFF, 8'h00};
      set_sel(SEL_D00);
      en = 1'b1;
      expect_val("load_a5", 8'hA5);
      @(posedge clk);
      #1;
      check_val(y8_q);
      #2;
      rst = 1'b1;
      expect_val("midcycle_rst_y8_q", 8'h00);
      expect_val("midcycle_rst_y8r_q", RST_ALT);
      expect_val("midcycle_rst_y", 8'hA5);
      #1;
      check_val(y8_q);
      check_val(y8r_q);
      check_val(y8);

      // Load FF via select 10.
      @(negedge clk);
      rst = 1'b0;
      set_sel(SEL_D10);
      expect_val("load_ff", 8'hFF);
      @(posedge clk);
      #1;
      check_val(y8_q);

      // Hold with en=0 while the select moves.
      @(negedge clk);
      en = 1'b0;
      set_sel(SEL_D01);
      expect_val("hold_y_01", 8'h3C);
      #1;
      check_val(y8);
      expect_val("hold_ff_1", 8'hFF);
      @(posedge clk);
      #1;
      check_val(y8_q);
      @(negedge clk);
      set_sel(SEL_D11);
      expect_val("hold_ff_2", 8'hFF);
      @(posedge clk);
      #1;
      check_val(y8_q);

      // rst and en both high at an edge: reset wins, y still follows.
      @(negedge clk);
      rst = 1'b1;
      en  = 1'b1;
      set_sel(SEL_D00);
      expect_val("rst_en_y8_q", 8'h00);
      expect_val("rst_en_y8r_q", RST_ALT);
      expect_val("rst_en_y", 8'hA5);
      @(posedge clk);
      #1;
      check_val(y8_q);
      check_val(y8r_q);
      check_val(y8);
      set_sel(SEL_D01);
      expect_val("rst_en_y_follow", 8'h3C);
      #1;
      check_val(y8);

      // First edge after reset release loads the current selection.
      @(negedge clk);
      rst = 1'b0;
      {a00, a01, a10, a11} = 4'b0100;
      expect_val("post_rst_y8_q", 8'h3C);
      expect_val("post_rst_y8r_q", 8'h3C);
      expect_val("post_rst_y1_q", 8'h01);
      @(posedge clk);
      #1;
      check_val(y8_q);
      check_val(y8r_q);
      check_val({7'd0, y1_q});

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: got %0d entries, required 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
